// File: rtl/noc_sequencer.sv
// noc_sequencer: control sequencer for the NoC router array.
// Order of work: router init, then a handshaked routing-table download,
// then repeating LoadStaging/Phase0/Phase1 network cycles. The cycles stop
// on a cycle budget or when every router reports done, and can be paused.
// Every output is a register. It reflects the state the FSM held just
// before the clock edge that loaded it.
module noc_sequencer #(
  parameter int NUM_ROUTERS = 4,
  parameter int ROUTER_BITS = 2,
  parameter int PORT_BITS   = 3,
  parameter int OP_BITS     = 4,
  parameter int CYCLE_BITS  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 pause,
  input  logic [CYCLE_BITS-1:0]                max_cycle,
  output logic                                 rt_rd_en,
  output logic [ROUTER_BITS-1:0]               rt_rd_addr,
  input  logic [NUM_ROUTERS*(PORT_BITS+1)-1:0] rt_rd_data,
  input  logic [NUM_ROUTERS-1:0]               router_done,
  output logic [NUM_ROUTERS*OP_BITS-1:0]       router_op,
  output logic [NUM_ROUTERS*PORT_BITS-1:0]     rt_port,
  output logic [ROUTER_BITS-1:0]               rt_dst,
  output logic [CYCLE_BITS-1:0]                in_cycle,
  output logic                                 busy,
  output logic                                 finished,
  output logic [1:0]                           term_cause
);

  localparam logic [OP_BITS-1:0] OP_NOP    = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_INIT   = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_LOADRT = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_STAGE  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_PH0    = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_PH1    = OP_BITS'(5);

  localparam logic [ROUTER_BITS-1:0] LAST_DST = ROUTER_BITS'(NUM_ROUTERS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RT_RD, S_RT_WR, S_STAGE, S_PH0, S_PH1, S_HOLD, S_DONE
  } state_t;

  state_t                                r_state;
  logic [ROUTER_BITS-1:0]                r_dst;
  logic [CYCLE_BITS-1:0]                 r_max;
  logic [NUM_ROUTERS-1:0][OP_BITS-1:0]   r_op;
  logic [NUM_ROUTERS-1:0][PORT_BITS-1:0] r_port;
  logic [ROUTER_BITS-1:0]                r_rt_dst;
  logic                                  r_rd_en;
  logic [ROUTER_BITS-1:0]                r_rd_addr;
  logic [CYCLE_BITS-1:0]                 r_in_cycle;
  logic                                  r_busy;
  logic                                  r_finished;
  logic [1:0]                            r_term;

  logic [NUM_ROUTERS-1:0]                w_lane_valid;
  logic [NUM_ROUTERS-1:0][PORT_BITS-1:0] w_lane_port;
  logic [NUM_ROUTERS-1:0][OP_BITS-1:0]   w_wr_op;
  logic [NUM_ROUTERS-1:0][PORT_BITS-1:0] w_wr_port;
  logic [CYCLE_BITS-1:0]                 w_cycle_inc;
  logic                                  w_budget_hit;
  logic                                  w_all_done;

  // Split the table read data into lanes. A valid lane loads its port;
  // a lane without the valid bit keeps the port it already holds.
  for (genvar gi = 0; gi < NUM_ROUTERS; gi++) begin : g_lane
    assign w_lane_valid[gi] = rt_rd_data[gi*(PORT_BITS+1) + PORT_BITS];
    assign w_lane_port[gi]  = rt_rd_data[gi*(PORT_BITS+1) +: PORT_BITS];
    assign w_wr_op[gi]      = w_lane_valid[gi] ? OP_LOADRT : OP_NOP;
    assign w_wr_port[gi]    = w_lane_valid[gi] ? w_lane_port[gi] : r_port[gi];
  end

  assign w_cycle_inc  = r_in_cycle + 1'b1;
  assign w_budget_hit = (r_max != '0) && (w_cycle_inc == r_max);
  assign w_all_done   = &router_done;

  assign router_op  = r_op;
  assign rt_port    = r_port;
  assign rt_dst     = r_rt_dst;
  assign rt_rd_en   = r_rd_en;
  assign rt_rd_addr = r_rd_addr;
  assign in_cycle   = r_in_cycle;
  assign busy       = r_busy;
  assign finished   = r_finished;
  assign term_cause = r_term;

  // Sequencer FSM: state, op lanes and all status outputs in one register set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dst      <= '0;
      r_max      <= '0;
      r_op       <= '0;
      r_port     <= '0;
      r_rt_dst   <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_in_cycle <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_term     <= 2'd0;
    end else begin
      // The read strobe goes high on the edge that enters RT_RD. The table
      // then registers the data at the end of RT_RD, and RT_WR can use it.
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b1;
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_op       <= {NUM_ROUTERS{OP_NOP}};
          r_busy     <= 1'b0;
          r_finished <= (r_state == S_DONE);
          if (start) begin
            r_max      <= max_cycle;
            r_in_cycle <= '0;
            r_term     <= 2'd0;
            r_state    <= S_INIT;
          end
        end
        S_INIT: begin
          r_op      <= {NUM_ROUTERS{OP_INIT}};
          r_dst     <= '0;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
          r_state   <= S_RT_RD;
        end
        S_RT_RD: begin
          r_op    <= {NUM_ROUTERS{OP_NOP}};
          r_state <= S_RT_WR;
        end
        S_RT_WR: begin
          r_op     <= w_wr_op;
          r_port   <= w_wr_port;
          r_rt_dst <= r_dst;
          if (r_dst == LAST_DST) begin
            r_state <= S_STAGE;
          end else begin
            r_dst     <= r_dst + 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_dst + 1'b1;
            r_state   <= S_RT_RD;
          end
        end
        S_STAGE: begin
          r_op    <= {NUM_ROUTERS{OP_STAGE}};
          r_state <= S_PH0;
        end
        S_PH0: begin
          r_op    <= {NUM_ROUTERS{OP_PH0}};
          r_state <= S_PH1;
        end
        S_PH1: begin
          r_op       <= {NUM_ROUTERS{OP_PH1}};
          r_in_cycle <= w_cycle_inc;
          // The budget takes priority over all-done, and both take priority over pause.
          if (w_budget_hit) begin
            r_term  <= 2'd1;
            r_state <= S_DONE;
          end else if (w_all_done) begin
            r_term  <= 2'd2;
            r_state <= S_DONE;
          end else if (pause) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_STAGE;
          end
        end
        S_HOLD: begin
          r_op <= {NUM_ROUTERS{OP_NOP}};
          if (!pause) r_state <= S_STAGE;
        end
        default: begin
          r_op    <= {NUM_ROUTERS{OP_NOP}};
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_sequencer.sv
// Testbench for noc_sequencer. A reference model builds the expected
// per-clock output trace of each run from the sequencing rules. The bench
// drives randomized inputs along that timeline and checks every output
// after each clock.
module tb_noc_sequencer;

  localparam int N  = 4;
  localparam int RB = 2;
  localparam int PB = 3;
  localparam int OB = 4;
  localparam int CB = 16;

  localparam int K_INIT = 0, K_RD = 1, K_WR = 2, K_ST = 3, K_P0 = 4,
                 K_P1 = 5, K_HOLD = 6, K_DONE = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              pause;
  logic [CB-1:0]     max_cycle;
  logic              rt_rd_en;
  logic [RB-1:0]     rt_rd_addr;
  logic [N*(PB+1)-1:0] rt_rd_data = '0;
  logic [N-1:0]      router_done;
  logic [N*OB-1:0]   router_op;
  logic [N*PB-1:0]   rt_port;
  logic [RB-1:0]     rt_dst;
  logic [CB-1:0]     in_cycle;
  logic              busy;
  logic              finished;
  logic [1:0]        term_cause;

  always #5 clk = ~clk;

  noc_sequencer #(
    .NUM_ROUTERS(N), .ROUTER_BITS(RB), .PORT_BITS(PB), .OP_BITS(OB), .CYCLE_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .max_cycle(max_cycle),
    .rt_rd_en(rt_rd_en), .rt_rd_addr(rt_rd_addr), .rt_rd_data(rt_rd_data),
    .router_done(router_done), .router_op(router_op), .rt_port(rt_port),
    .rt_dst(rt_dst), .in_cycle(in_cycle), .busy(busy), .finished(finished),
    .term_cause(term_cause)
  );

  // Routing table [dst][router] = {valid, port}, registered read.
  logic [PB:0] tbl [N][N];

  // Table memory: data appears one clock after the read strobe.
  always @(posedge clk) begin
    if (rt_rd_en)
      for (int i = 0; i < N; i++) rt_rd_data[i*(PB+1) +: PB+1] <= tbl[rt_rd_addr][i];
  end

  typedef struct {
    int            kind;
    int            cyc;
    int            hlast;
    logic [N*OB-1:0] ops;
    logic [N*PB-1:0] port;
    logic [RB-1:0] dst;
    logic          rd_en;
    logic [RB-1:0] rd_addr;
    logic [CB-1:0] inc;
    logic          busy;
    logic          fin;
    logic [1:0]    term;
  } exp_t;

  exp_t          exp_q[$];
  logic [PB-1:0] m_port [N];
  logic [RB-1:0] m_dst;
  logic [RB-1:0] m_addr;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_ph1;

  function automatic logic [N*OB-1:0] all_op(input int op);
    logic [N*OB-1:0] r;
    for (int i = 0; i < N; i++) r[i*OB +: OB] = OB'(op);
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_not_all();
    logic [N-1:0] v;
    v = N'($urandom);
    v[$urandom % N] = 1'b0;
    return v;
  endfunction

  task automatic push(input int kind, input int cyc, input int hlast, input logic [N*OB-1:0] ops,
                      input logic rd_en, input logic [CB-1:0] inc, input logic b,
                      input logic f, input logic [1:0] term);
    exp_t e;
    e.kind = kind; e.cyc = cyc; e.hlast = hlast; e.ops = ops; e.rd_en = rd_en;
    e.inc = inc; e.busy = b; e.fin = f; e.term = term;
    e.dst = m_dst; e.rd_addr = m_addr;
    for (int i = 0; i < N; i++) e.port[i*PB +: PB] = m_port[i];
    exp_q.push_back(e);
  endtask

  // Reference model: expected outputs after each clock following the start edge.
  task automatic build_model(input int maxc, input int done_c, input int pause_c, input int pause_l);
    int c;
    logic [CB-1:0] inc;
    logic [1:0] term;
    logic [N*OB-1:0] ops;
    exp_q.delete();
    inc = '0;
    term = 2'd0;
    m_addr = '0;
    push(K_INIT, 0, 0, all_op(1), 1'b1, inc, 1'b1, 1'b0, term);
    for (int d = 0; d < N; d++) begin
      push(K_RD, 0, 0, all_op(0), 1'b0, inc, 1'b1, 1'b0, term);
      ops = '0;
      for (int i = 0; i < N; i++) begin
        if (tbl[d][i][PB]) begin
          ops[i*OB +: OB] = OB'(2);
          m_port[i] = tbl[d][i][PB-1:0];
        end
      end
      m_dst = RB'(d);
      if (d < N - 1) m_addr = RB'(d + 1);
      push(K_WR, 0, 0, ops, (d < N - 1), inc, 1'b1, 1'b0, term);
    end
    c = 1;
    while (term == 2'd0) begin
      push(K_ST, c, 0, all_op(3), 1'b0, inc, 1'b1, 1'b0, term);
      push(K_P0, c, 0, all_op(4), 1'b0, inc, 1'b1, 1'b0, term);
      inc = CB'(c);
      if (maxc != 0 && c == maxc) term = 2'd1;
      else if (done_c != 0 && c >= done_c) term = 2'd2;
      push(K_P1, c, 0, all_op(5), 1'b0, inc, 1'b1, 1'b0, term);
      if (term == 2'd0 && c == pause_c)
        for (int j = 1; j <= pause_l; j++)
          push(K_HOLD, c, (j == pause_l), all_op(0), 1'b0, inc, 1'b1, 1'b0, term);
      c++;
    end
    for (int j = 0; j < 3; j++) push(K_DONE, c, 0, all_op(0), 1'b0, inc, 1'b0, 1'b1, term);
  endtask

  // Start a run and check every output against the model trace, clock by clock.
  task automatic run_program(input string name, input int maxc, input int done_c,
                             input int pause_c, input int pause_l);
    exp_t e;
    build_model(maxc, done_c, pause_c, pause_l);
    n_ph1 = 0;
    max_cycle = CB'(maxc);
    start = 1'b1;
    pause = 1'($urandom);
    router_done = rnd_not_all();
    @(posedge clk);
    foreach (exp_q[t]) begin
      @(negedge clk);
      e = exp_q[t];
      start = (e.kind != K_DONE) && ($urandom % 4 == 0);
      max_cycle = CB'($urandom);
      if (e.kind == K_P1) begin
        pause = (e.cyc == pause_c);
        router_done = (done_c != 0 && e.cyc >= done_c) ? '1 : rnd_not_all();
      end else if (e.kind == K_HOLD) begin
        pause = (e.hlast == 0);
        router_done = rnd_not_all();
      end else begin
        pause = 1'($urandom);
        router_done = rnd_not_all();
      end
      @(posedge clk);
      #1;
      if (router_op == all_op(5)) n_ph1++;
      n_cmp++;
      if (router_op !== e.ops) begin
        n_bad++; $display("FAIL %s t=%0d router_op got %h want %h", name, t, router_op, e.ops);
      end
      n_cmp++;
      if (rt_port !== e.port) begin
        n_bad++; $display("FAIL %s t=%0d rt_port got %h want %h", name, t, rt_port, e.port);
      end
      n_cmp++;
      if (rt_dst !== e.dst) begin
        n_bad++; $display("FAIL %s t=%0d rt_dst got %0d want %0d", name, t, rt_dst, e.dst);
      end
      n_cmp++;
      if ({rt_rd_en, rt_rd_addr} !== {e.rd_en, e.rd_addr}) begin
        n_bad++; $display("FAIL %s t=%0d rd_en/addr got %b/%0d want %b/%0d", name, t,
                          rt_rd_en, rt_rd_addr, e.rd_en, e.rd_addr);
      end
      n_cmp++;
      if (in_cycle !== e.inc) begin
        n_bad++; $display("FAIL %s t=%0d in_cycle got %0d want %0d", name, t, in_cycle, e.inc);
      end
      n_cmp++;
      if ({busy, finished, term_cause} !== {e.busy, e.fin, e.term}) begin
        n_bad++; $display("FAIL %s t=%0d busy/fin/term got %b%b/%0d want %b%b/%0d", name, t,
                          busy, finished, term_cause, e.busy, e.fin, e.term);
      end
    end
    start = 1'b0;
    $display("run %s max=%0d done_c=%0d pause_c=%0d pause_l=%0d clocks=%0d in_cycle=%0d term=%0d",
             name, maxc, done_c, pause_c, pause_l, exp_q.size(), in_cycle, term_cause);
  endtask

  task automatic set_table_random();
    for (int d = 0; d < N; d++)
      for (int i = 0; i < N; i++) tbl[d][i] = {($urandom % 4 != 0), PB'($urandom)};
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) m_port[i] = '0;
    m_dst = '0;
    m_addr = '0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (router_op !== '0) begin n_bad++; $display("FAIL reset router_op got %h want 0", router_op); end
    n_cmp++;
    if ({rt_port, rt_dst, rt_rd_addr} !== '0) begin
      n_bad++; $display("FAIL reset port/dst/addr got %h/%0d/%0d want 0", rt_port, rt_dst, rt_rd_addr);
    end
    n_cmp++;
    if ({in_cycle, term_cause} !== '0) begin
      n_bad++; $display("FAIL reset in_cycle/term got %0d/%0d want 0", in_cycle, term_cause);
    end
    n_cmp++;
    if ({rt_rd_en, busy, finished} !== 3'b000) begin
      n_bad++; $display("FAIL reset en/busy/fin got %b%b%b want 000", rt_rd_en, busy, finished);
    end
    $display("reset check done");
  endtask

  task automatic test_download_budget();
    for (int d = 0; d < N; d++)
      for (int i = 0; i < N; i++) tbl[d][i] = {1'b1, PB'(d)};
    tbl[1][2][PB] = 1'b0;
    clear_model();
    rst = 1'b0;
    run_program("budget3", 3, 0, 0, 0);
    n_cmp++;
    if (n_ph1 != 3) begin n_bad++; $display("FAIL budget3 phase1_count got %0d want 3", n_ph1); end
    n_cmp++;
    if ({finished, in_cycle, term_cause} !== {1'b1, CB'(3), 2'd1}) begin
      n_bad++; $display("FAIL budget3 final fin/in_cycle/term got %b/%0d/%0d want 1/3/1",
                        finished, in_cycle, term_cause);
    end
  endtask

  task automatic test_all_done();
    set_table_random();
    run_program("alldone", 0, 5, 0, 0);
    n_cmp++;
    if ({in_cycle, term_cause} !== {CB'(5), 2'd2}) begin
      n_bad++; $display("FAIL alldone in_cycle/term got %0d/%0d want 5/2", in_cycle, term_cause);
    end
  endtask

  task automatic test_both_conditions();
    set_table_random();
    run_program("both", 4, 4, 0, 0);
    n_cmp++;
    if ({in_cycle, term_cause} !== {CB'(4), 2'd1}) begin
      n_bad++; $display("FAIL both in_cycle/term got %0d/%0d want 4/1", in_cycle, term_cause);
    end
  endtask

  task automatic test_pause();
    set_table_random();
    run_program("pause4", 0, 4, 2, 4);
    n_cmp++;
    if ({in_cycle, term_cause} !== {CB'(4), 2'd2}) begin
      n_bad++; $display("FAIL pause4 in_cycle/term got %0d/%0d want 4/2", in_cycle, term_cause);
    end
    run_program("pause1", 2, 0, 1, 1);
    n_cmp++;
    if (n_ph1 != 2) begin n_bad++; $display("FAIL pause1 phase1_count got %0d want 2", n_ph1); end
  endtask

  task automatic test_reset_mid();
    set_table_random();
    @(negedge clk);
    max_cycle = CB'(2);
    pause = 1'b0;
    router_done = '0;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({router_op, rt_port, rt_dst, rt_rd_addr, in_cycle, term_cause} !== '0) begin
      n_bad++; $display("FAIL rst_mid values got op=%h port=%h dst=%0d addr=%0d inc=%0d term=%0d want 0",
                        router_op, rt_port, rt_dst, rt_rd_addr, in_cycle, term_cause);
    end
    n_cmp++;
    if ({rt_rd_en, busy, finished} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid en/busy/fin got %b%b%b want 000", rt_rd_en, busy, finished);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    run_program("after_rst", 2, 0, 0, 0);
  endtask

  task automatic test_restart();
    int m;
    n_cmp++;
    if ({finished, term_cause} !== {1'b1, 2'd1}) begin
      n_bad++; $display("FAIL restart pre fin/term got %b/%0d want 1/1", finished, term_cause);
    end
    m = $urandom_range(1, 3);
    run_program("restart", m, 0, 0, 0);
    n_cmp++;
    if (n_ph1 != m) begin n_bad++; $display("FAIL restart phase1_count got %0d want %0d", n_ph1, m); end
  endtask

  task automatic test_random_runs();
    int maxc, done_c, exp_inc;
    logic [1:0] exp_term;
    for (int r = 0; r < 4; r++) begin
      set_table_random();
      maxc = $urandom_range(0, 5);
      done_c = $urandom_range(0, 6);
      if (maxc == 0 && done_c == 0) done_c = 3;
      if (maxc != 0 && (done_c == 0 || maxc <= done_c)) begin
        exp_term = 2'd1; exp_inc = maxc;
      end else begin
        exp_term = 2'd2; exp_inc = done_c;
      end
      run_program("random", maxc, done_c, $urandom_range(0, 4), $urandom_range(1, 5));
      n_cmp++;
      if ({in_cycle, term_cause} !== {CB'(exp_inc), exp_term}) begin
        n_bad++; $display("FAIL random%0d in_cycle/term got %0d/%0d want %0d/%0d", r,
                          in_cycle, term_cause, exp_inc, exp_term);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    max_cycle = '0;
    router_done = '0;
    test_reset();
    test_download_budget();
    test_all_done();
    test_both_conditions();
    test_pause();
    test_reset_mid();
    test_restart();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
